// File: rtl/health_pkg.sv
// Shared types for the health-monitor report path: record layout, categories
// and the transmit framing FSM states.
package health_pkg;

  typedef enum logic [1:0] {
    UNDER  = 2'd0,
    NORMAL = 2'd1,
    OVER   = 2'd2,
    OBESE  = 2'd3
  } hc_e;

  typedef struct packed {
    hc_e        hc;
    logic [5:0] bmi;
  } bmi_rec_t;

  localparam logic [7:0] HDR_BYTE_DFLT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM
  } tx_state_e;

endpackage

// File: rtl/health_fifo.sv
// Synchronous FIFO with registered full/empty flags; a pop on the same edge
// frees a slot, so push is accepted even when full.
module health_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head_c,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt_q <= cnt_d;
      full  <= (cnt_d == CW'(DEPTH));
      empty <= (cnt_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/health_report_tx.sv
// Buffers BMI results from the monitor and serializes each as a
// header/data/checksum byte frame, with category and drop statistics.
module health_report_tx
  import health_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DFLT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [5:0]       bmi_ratio,
  input  logic [1:0]       hc_indicator,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_last,
  input  logic             tx_ready,
  input  logic             clr_stats,
  input  logic [1:0]       cat_sel,
  output logic [CNT_W-1:0] cat_count,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  tx_state_e        state_q;
  tx_state_e        state_d;
  bmi_rec_t         in_q;
  logic             in_vld_q;
  bmi_rec_t         head;
  bmi_rec_t         hold_q;
  bmi_rec_t         hold_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             hs;
  logic             drop;
  logic [7:0]       data_d;
  logic             tx_valid_d;
  logic [7:0]       tx_data_d;
  logic             tx_last_d;
  logic [CNT_W-1:0] cat_q [4];

  // Input capture register decouples the monitor's timing from the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q <= 1'b0;
      in_q     <= '0;
    end else begin
      in_vld_q <= valid_i;
      in_q.hc  <= hc_e'(hc_indicator);
      in_q.bmi <= bmi_ratio;
    end
  end

  health_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(bmi_rec_t))
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (in_vld_q),
    .din    (in_q),
    .pop    (pop),
    .head_c (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign hs   = tx_valid & tx_ready;
  assign drop = in_vld_q & fifo_full & ~pop;

  // Next-state logic; tx outputs are registered from the next state so a
  // byte is presented on the same edge the FSM enters its state.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    tx_last_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_HDR;
        end
      end
      ST_HDR:  if (hs) state_d = ST_DATA;
      ST_DATA: if (hs) state_d = ST_CSUM;
      ST_CSUM: begin
        if (hs) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hold_d = pop ? head : hold_q;
    data_d = 8'(hold_d);
    unique case (state_d)
      ST_HDR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HDR_BYTE;
      end
      ST_DATA: begin
        tx_valid_d = 1'b1;
        tx_data_d  = data_d;
      end
      ST_CSUM: begin
        tx_valid_d = 1'b1;
        tx_data_d  = HDR_BYTE ^ data_d;
        tx_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_last  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      tx_last  <= tx_last_d;
    end
  end

  // Statistics: a clear on the same edge overrides any sample or drop.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      for (int i = 0; i < 4; i++) cat_q[i] <= '0;
      drop_cnt <= 8'h00;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (valid_i && hc_indicator == 2'(i) && cat_q[i] != '1)
          cat_q[i] <= cat_q[i] + CNT_W'(1);
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  assign cat_count = cat_q[cat_sel];

endmodule

// File: tb/tb_health_report_tx.sv
// Directed and randomized checks of health_report_tx against a byte-level
// frame model and per-category count model.
module tb_health_report_tx;

  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic [5:0]       bmi_ratio;
  logic [1:0]       hc_indicator;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_last;
  logic             tx_ready;
  logic             clr_stats;
  logic [1:0]       cat_sel;
  logic [CNT_W-1:0] cat_count;
  logic [7:0]       drop_cnt;
  logic             overflow;

  int    n_pass = 0;
  int    n_chk  = 0;
  int    n_fail = 0;
  byte_t exp_q[$];
  byte_t cap_q[$];
  int    exp_cat[4];
  logic  held_pend = 1'b0;
  byte_t held_b;

  always #5 clk = ~clk;

  health_report_tx #(
    .DEPTH    (4),
    .HDR_BYTE (8'hA5),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .bmi_ratio    (bmi_ratio),
    .hc_indicator (hc_indicator),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .clr_stats    (clr_stats),
    .cat_sel      (cat_sel),
    .cat_count    (cat_count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink: record accepted bytes and verify stalled bytes stay stable.
  always @(negedge clk) begin
    if (held_pend) begin
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_byte", 32'({tx_data, tx_last}), 32'(held_b));
    end
    if (tx_valid && tx_ready && !rst) cap_q.push_back('{d: tx_data, l: tx_last});
    held_pend = tx_valid && !tx_ready && !rst;
    held_b    = '{d: tx_data, l: tx_last};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] bmi, input logic [1:0] hc);
    bmi_ratio    = bmi;
    hc_indicator = hc;
    valid_i      = 1'b1;
    if (!clr_stats) exp_cat[hc]++;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic add_frame(input logic [5:0] bmi, input logic [1:0] hc);
    logic [7:0] d;
    d = {hc, bmi};
    exp_q.push_back('{d: 8'hA5, l: 1'b0});
    exp_q.push_back('{d: d, l: 1'b0});
    exp_q.push_back('{d: 8'hA5 ^ d, l: 1'b1});
  endtask

  task automatic wait_bytes(input int n);
    for (int k = 0; k < 300 && cap_q.size() < n; k++) tick();
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_nbytes"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(cap_q[i].d), 32'(exp_q[i].d));
      chk({tag, "_last"}, 32'(cap_q[i].l), 32'(exp_q[i].l));
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cats(input string tag);
    for (int c = 0; c < 4; c++) begin
      cat_sel = 2'(c);
      #1;
      chk(tag, 32'(cat_count), 32'(exp_cat[c]));
    end
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    for (int c = 0; c < 4; c++) exp_cat[c] = 0;
  endtask

  initial begin
    logic [5:0] rb [3];
    logic [1:0] rh [3];
    int         sum;

    rst = 1'b1; valid_i = 1'b0; bmi_ratio = '0; hc_indicator = '0;
    tx_ready = 1'b0; clr_stats = 1'b0; cat_sel = '0;
    for (int c = 0; c < 4; c++) exp_cat[c] = 0;
    repeat (3) tick();

    // Reset state
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_last", 32'(tx_last), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    check_cats("rst_cat");
    rst = 1'b0;
    tick();

    // Single result, latency and byte order
    tx_ready = 1'b1;
    add_frame(6'd22, 2'd1);
    send(6'd22, 2'd1);
    tick();
    chk("lat_e1_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_e2_valid", 32'(tx_valid), 32'd1);
    chk("single_b0", 32'({tx_data, tx_last}), 32'({8'hA5, 1'b0}));
    tick();
    chk("single_b1", 32'({tx_data, tx_last}), 32'({8'h56, 1'b0}));
    tick();
    chk("single_b2", 32'({tx_data, tx_last}), 32'({8'hF3, 1'b1}));
    tick();
    chk("single_idle", 32'(tx_valid), 32'd0);
    compare_stream("single");

    // Backpressure with ready toggling
    tx_ready = 1'b0;
    add_frame(6'd35, 2'd3);
    send(6'd35, 2'd3);
    for (int k = 0; k < 24; k++) begin
      tx_ready = ~tx_ready;
      tick();
    end
    tx_ready = 1'b1;
    wait_bytes(3);
    compare_stream("bp");

    // Back-to-back frames
    clear_stats();
    for (int r = 0; r < 3; r++) begin
      rb[r] = 6'($urandom_range(0, 63));
      rh[r] = 2'($urandom_range(0, 3));
      add_frame(rb[r], rh[r]);
    end
    for (int r = 0; r < 3; r++) send(rb[r], rh[r]);
    for (int k = 0; k < 9; k++) begin
      chk("b2b_valid", 32'(tx_valid), 32'd1);
      tick();
    end
    wait_bytes(9);
    compare_stream("b2b");
    check_cats("b2b_cat");

    // Overflow: six results against a stalled sink
    clear_stats();
    tx_ready = 1'b0;
    for (int r = 0; r < 6; r++) begin
      bmi_ratio = 6'($urandom_range(0, 63));
      hc_indicator = 2'($urandom_range(0, 3));
      if (r < 5) add_frame(bmi_ratio, hc_indicator);
      send(bmi_ratio, hc_indicator);
    end
    repeat (4) tick();
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    tx_ready = 1'b1;
    wait_bytes(15);
    repeat (10) tick();
    compare_stream("ovf");
    check_cats("ovf_cat");
    sum = 0;
    for (int c = 0; c < 4; c++) begin
      cat_sel = 2'(c);
      #1;
      sum += int'(cat_count);
    end
    chk("ovf_cat_sum", 32'(sum), 32'd6);

    // Clear on the same edge as a sample
    clr_stats = 1'b1;
    add_frame(6'd27, 2'd2);
    send(6'd27, 2'd2);
    clr_stats = 1'b0;
    for (int c = 0; c < 4; c++) exp_cat[c] = 0;
    cat_sel = 2'd2;
    #1;
    chk("clr_cat2", 32'(cat_count), 32'd0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    wait_bytes(3);
    compare_stream("clr");

    // Reset during the data byte with records still queued
    tx_ready = 1'b1;
    exp_q.push_back('{d: 8'hA5, l: 1'b0});
    send(6'd10, 2'd0);
    send(6'd40, 2'd2);
    send(6'd50, 2'd3);
    for (int k = 0; k < 20; k++) begin
      if (tx_valid && tx_data == 8'h0A) break;
      tick();
    end
    chk("rstmid_at_data", 32'(tx_data), 32'h0A);
    rst = 1'b1;
    tx_ready = 1'b0;
    tick();
    chk("rstmid_valid", 32'(tx_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) exp_cat[c] = 0;
    tx_ready = 1'b1;
    repeat (12) tick();
    chk("rstmid_idle", 32'(tx_valid), 32'd0);
    compare_stream("rstmid");
    add_frame(6'd30, 2'd2);
    send(6'd30, 2'd2);
    wait_bytes(3);
    compare_stream("post_rst");

    // Randomized traffic
    for (int r = 0; r < 12; r++) begin
      bmi_ratio = 6'($urandom_range(0, 63));
      hc_indicator = 2'($urandom_range(0, 3));
      add_frame(bmi_ratio, hc_indicator);
      send(bmi_ratio, hc_indicator);
      for (int g = 0; g < int'($urandom_range(6, 9)); g++) begin
        tx_ready = ($urandom_range(0, 7) != 0);
        tick();
      end
    end
    tx_ready = 1'b1;
    wait_bytes(36);
    repeat (5) tick();
    compare_stream("rand");
    check_cats("rand_cat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
